sram_scr_init_ctrl: RTL

- Sequencing controller in front of the scrambled single-port SRAM.
- Fetches a fresh scrambling key/nonce from the key source, then sweeps every word with pseudo-random write data so the memory never exposes stale plaintext.
- Afterwards, passes host traffic to the RAM.
- Owns key_valid for the RAM and latches escalation into a permanent lock.

---
 rtl/sram_scr_init_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sram_scr_init_ctrl.sv
// Key fetch + pseudo-random wipe sequencer in front of the scrambled SRAM, then host pass-through.
// Optional init-cycle counter port is enabled by defining SRAM_SCR_INIT_PERF_EN.
module sram_scr_init_ctrl #(
    parameter int          Depth      = 16384,
    parameter int          Width      = 32,
    parameter int          NonceWidth = 64,
    parameter logic [31:0] LfsrSeed   = 32'hACE1_2468,
    localparam int         AddrWidth  = (Depth == 1) ? 1 : $clog2(Depth)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  init_req_i,
    input  logic                  escalate_i,
    output logic                  key_req_o,
    input  logic                  key_ack_i,
    input  logic [127:0]          key_i,
    input  logic [NonceWidth-1:0] nonce_i,
    output logic                  key_valid_o,
    output logic [127:0]          key_o,
    output logic [NonceWidth-1:0] nonce_o,
    input  logic                  host_req_i,
    output logic                  host_gnt_o,
    input  logic                  host_write_i,
    input  logic [AddrWidth-1:0]  host_addr_i,
    input  logic [Width-1:0]      host_wdata_i,
    input  logic [Width-1:0]      host_wmask_i,
    output logic                  ram_req_o,
    input  logic                  ram_gnt_i,
    output logic                  ram_write_o,
    output logic [AddrWidth-1:0]  ram_addr_o,
    output logic [Width-1:0]      ram_wdata_o,
    output logic [Width-1:0]      ram_wmask_o,
    output logic                  init_done_o,
    output logic                  locked_o
`ifdef SRAM_SCR_INIT_PERF_EN
    ,
    output logic [31:0]           init_cycles_o
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] KEY_REQ = 3'd1;
    localparam logic [2:0] INIT    = 3'd2;
    localparam logic [2:0] READY   = 3'd3;
    localparam logic [2:0] LOCKED  = 3'd4;

    localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(Depth - 1);
    localparam logic [31:0]          LfsrTaps  = 32'h8020_0003;

    logic [2:0]            state_q, state_d;
    logic [127:0]          key_q, key_d;
    logic [NonceWidth-1:0] nonce_q, nonce_d;
    logic [AddrWidth-1:0]  cnt_q, cnt_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [31:0]           lfsr_step;
    logic [Width-1:0]      lfsr_rep;

    // Galois right-shift step: feed the dropped LSB back through the tap mask.
    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 32'h0);

    for (genvar gi = 0; gi < Width; gi++) begin : g_rep
        assign lfsr_rep[gi] = lfsr_q[gi % 32];
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            IDLE: begin
                if (init_req_i) state_d = KEY_REQ;
            end
            KEY_REQ: begin
                if (key_ack_i) begin
                    key_d   = key_i;
                    nonce_d = nonce_i;
                    cnt_d   = '0;
                    lfsr_d  = LfsrSeed;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (ram_gnt_i) begin
                    lfsr_d = lfsr_step;
                    if (cnt_q == LastAddr) state_d = READY;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (init_req_i) state_d = KEY_REQ;
            end
            default: begin
                state_d = LOCKED;
                key_d   = '0;
                nonce_d = '0;
            end
        endcase
        // Escalation wins over every other transition, including a same-cycle key ack.
        if (escalate_i) begin
            state_d = LOCKED;
            key_d   = '0;
            nonce_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            key_q   <= '0;
            nonce_q <= '0;
            cnt_q   <= '0;
            lfsr_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        key_req_o   = 1'b0;
        key_valid_o = 1'b0;
        host_gnt_o  = 1'b0;
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        init_done_o = 1'b0;
        locked_o    = 1'b0;
        case (state_q)
            KEY_REQ: key_req_o = 1'b1;
            INIT: begin
                key_valid_o = 1'b1;
                ram_req_o   = 1'b1;
                ram_write_o = 1'b1;
                ram_addr_o  = cnt_q;
                ram_wdata_o = lfsr_rep;
                ram_wmask_o = '1;
            end
            READY: begin
                init_done_o = 1'b1;
                key_valid_o = 1'b1;
                ram_req_o   = host_req_i;
                ram_write_o = host_write_i;
                ram_addr_o  = host_addr_i;
                ram_wdata_o = host_wdata_i;
                ram_wmask_o = host_wmask_i;
                host_gnt_o  = ram_gnt_i;
            end
            LOCKED:  locked_o = 1'b1;
            default: ;
        endcase
        // Cut the key and RAM access in the very cycle escalation appears.
        if (escalate_i) begin
            key_valid_o = 1'b0;
            ram_req_o   = 1'b0;
            host_gnt_o  = 1'b0;
        end
    end

    assign key_o   = key_q;
    assign nonce_o = nonce_q;

`ifdef SRAM_SCR_INIT_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_d == LOCKED || state_q == LOCKED) begin
            perf_d = '0;
        end else if (state_d == KEY_REQ && state_q != KEY_REQ) begin
            perf_d = '0;
        end else if ((state_q == KEY_REQ || state_q == INIT) && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perf_q <= '0;
        else         perf_q <= perf_d;
    end

    assign init_cycles_o = perf_q;
`endif

endmodule
